// File: rtl/snake_step_seq.sv
// Game-side sequencer for the snake occupancy RAM: clears/seeds the grid after reset, then runs one move per tick.
// Step latency 5-6 cycles (FIN at T5/T6); tick is only accepted in IDLE and dropped while busy or dead.
module snake_step_seq #(
    parameter int WIDTH     = 40,
    parameter int HEIGHT    = 30,
    parameter int INIT_ADDR = 607,
    parameter int INIT_LEN  = 3
) (
    input  logic        clk_25M,
    input  logic        rst,
    input  logic        tick,
    input  logic [1:0]  dir,
    input  logic [5:0]  head_x,
    input  logic [5:0]  head_y,
    input  logic [5:0]  tail_x,
    input  logic [5:0]  tail_y,
    input  logic [5:0]  apple_x,
    input  logic [5:0]  apple_y,
    output logic [10:0] ram_addr,
    output logic        ram_we,
    output logic        ram_din,
    input  logic        ram_dout,
    output logic        busy,
    output logic        done,
    output logic        grow,
    output logic        dead,
    output logic [5:0]  new_x,
    output logic [5:0]  new_y
);

    localparam logic [10:0] CELLS      = 11'(WIDTH * HEIGHT);
    localparam logic [10:0] SEED_FIRST = 11'(INIT_ADDR);
    localparam logic [10:0] SEED_END   = 11'(INIT_ADDR + INIT_LEN);

    typedef enum logic [3:0] {
        CLEAR, IDLE, CALC, READ, DECIDE, WRHEAD, ERTAIL, FIN, DEAD
    } state_t;

    state_t      state, state_n;
    logic [10:0] sweep, sweep_n;

    logic [5:0]  nx, ny;
    logic        wall, is_apple, is_tail;
    logic [10:0] chk_addr;

    logic [5:0]  cx, cy;
    logic        c_wall;
    logic [10:0] c_addr, tail_addr;
    logic        collide, to_fin;

    logic [10:0] addr_n;
    logic        we_n, din_n, busy_n, done_n, grow_n, dead_n;
    logic [5:0]  new_x_n, new_y_n;

    // 6-bit wraparound: stepping left from x=0 lands on 63 and is caught as a wall.
    always_comb begin
        cx = head_x;
        cy = head_y;
        case (dir)
            2'b00:   cy = head_y - 6'd1;
            2'b01:   cy = head_y + 6'd1;
            2'b10:   cx = head_x - 6'd1;
            default: cx = head_x + 6'd1;
        endcase
    end

    assign c_wall    = (cx >= 6'(WIDTH)) || (cy >= 6'(HEIGHT));
    assign c_addr    = {5'd0, cy} * 11'(WIDTH) + {5'd0, cx};
    assign tail_addr = {5'd0, tail_y} * 11'(WIDTH) + {5'd0, tail_x};

    // The tail cell is vacated this step, so it is not a collision unless the snake grows.
    assign collide = ram_dout & ~(is_tail & ~is_apple);

    // Outputs are registered from the next-state decision so they line up with the state they belong to.
    always_comb begin
        state_n = state;
        sweep_n = sweep;
        addr_n  = ram_addr;
        we_n    = 1'b0;
        din_n   = 1'b0;
        busy_n  = busy;
        done_n  = 1'b0;
        grow_n  = 1'b0;
        dead_n  = dead;
        new_x_n = new_x;
        new_y_n = new_y;
        to_fin  = 1'b0;

        case (state)
            CLEAR: begin
                if (sweep == CELLS) begin
                    state_n = IDLE;
                    busy_n  = 1'b0;
                end else begin
                    addr_n  = sweep;
                    we_n    = 1'b1;
                    din_n   = (sweep >= SEED_FIRST) && (sweep < SEED_END);
                    sweep_n = sweep + 11'd1;
                end
            end
            IDLE: begin
                if (tick) begin
                    state_n = CALC;
                    busy_n  = 1'b1;
                end
            end
            CALC: begin
                state_n = READ;
                if (!c_wall) addr_n = c_addr;
            end
            READ: begin
                if (wall) begin
                    state_n = DEAD;
                    dead_n  = 1'b1;
                    busy_n  = 1'b0;
                end else begin
                    state_n = DECIDE;
                end
            end
            DECIDE: begin
                if (collide) begin
                    state_n = DEAD;
                    dead_n  = 1'b1;
                    busy_n  = 1'b0;
                end else begin
                    state_n = WRHEAD;
                    addr_n  = chk_addr;
                    we_n    = 1'b1;
                    din_n   = 1'b1;
                end
            end
            WRHEAD: begin
                if (is_apple || is_tail) begin
                    to_fin = 1'b1;
                end else begin
                    state_n = ERTAIL;
                    addr_n  = tail_addr;
                    we_n    = 1'b1;
                    din_n   = 1'b0;
                end
            end
            ERTAIL:  to_fin = 1'b1;
            FIN:     state_n = IDLE;
            DEAD:    state_n = DEAD;
            default: state_n = CLEAR;
        endcase

        if (to_fin) begin
            state_n = FIN;
            done_n  = 1'b1;
            grow_n  = is_apple;
            busy_n  = 1'b0;
            new_x_n = nx;
            new_y_n = ny;
        end
    end

    always_ff @(posedge clk_25M or posedge rst) begin
        if (rst) begin
            state    <= CLEAR;
            sweep    <= 11'd0;
            ram_addr <= 11'd0;
            ram_we   <= 1'b0;
            ram_din  <= 1'b0;
            busy     <= 1'b1;
            done     <= 1'b0;
            grow     <= 1'b0;
            dead     <= 1'b0;
            new_x    <= 6'd0;
            new_y    <= 6'd0;
        end else begin
            state    <= state_n;
            sweep    <= sweep_n;
            ram_addr <= addr_n;
            ram_we   <= we_n;
            ram_din  <= din_n;
            busy     <= busy_n;
            done     <= done_n;
            grow     <= grow_n;
            dead     <= dead_n;
            new_x    <= new_x_n;
            new_y    <= new_y_n;
        end
    end

    always_ff @(posedge clk_25M or posedge rst) begin
        if (rst) begin
            nx       <= 6'd0;
            ny       <= 6'd0;
            wall     <= 1'b0;
            chk_addr <= 11'd0;
            is_apple <= 1'b0;
            is_tail  <= 1'b0;
        end else if (state == CALC) begin
            nx       <= cx;
            ny       <= cy;
            wall     <= c_wall;
            chk_addr <= c_addr;
            is_apple <= (cx == apple_x) && (cy == apple_y);
            is_tail  <= (cx == tail_x) && (cy == tail_y);
        end
    end

endmodule

// File: tb/tb_snake_step_seq.sv
// Bench for snake_step_seq: behavioural RAM plus a grid-level model of one snake move.
module tb_snake_step_seq;

    logic        clk_25M = 1'b0;
    logic        rst = 1'b1;
    logic        tick = 1'b0;
    logic [1:0]  dir = 2'd0;
    logic [5:0]  head_x = 6'd0, head_y = 6'd0;
    logic [5:0]  tail_x = 6'd0, tail_y = 6'd0;
    logic [5:0]  apple_x = 6'd0, apple_y = 6'd0;
    logic [10:0] ram_addr;
    logic        ram_we, ram_din;
    logic        ram_dout;
    logic        busy, done, grow, dead;
    logic [5:0]  new_x, new_y;

    always #20 clk_25M = ~clk_25M;

    snake_step_seq dut (
        .clk_25M (clk_25M),
        .rst     (rst),
        .tick    (tick),
        .dir     (dir),
        .head_x  (head_x),
        .head_y  (head_y),
        .tail_x  (tail_x),
        .tail_y  (tail_y),
        .apple_x (apple_x),
        .apple_y (apple_y),
        .ram_addr(ram_addr),
        .ram_we  (ram_we),
        .ram_din (ram_din),
        .ram_dout(ram_dout),
        .busy    (busy),
        .done    (done),
        .grow    (grow),
        .dead    (dead),
        .new_x   (new_x),
        .new_y   (new_y)
    );

    // RAM with a one-cycle read, a write log, and a side port for arranging the grid.
    logic        mem [0:2047];
    logic [11:0] wr_log [0:16383];
    int          wr_cnt = 0;
    logic        poke_vld = 1'b0;
    logic [10:0] poke_addr = 11'd0;
    logic        poke_dat = 1'b0;

    always @(posedge clk_25M) begin
        if (ram_we) begin
            mem[ram_addr]          <= ram_din;
            wr_log[wr_cnt[13:0]]   <= {ram_din, ram_addr};
            wr_cnt                 <= wr_cnt + 1;
        end else if (poke_vld) begin
            mem[poke_addr] <= poke_dat;
        end
        ram_dout <= mem[ram_addr];
    end

    bit ref_grid [0:1199];
    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int nxt_x(input int hx, input int d);
        if (d == 2) return (hx + 63) % 64;
        if (d == 3) return (hx + 1) % 64;
        return hx;
    endfunction

    function automatic int nxt_y(input int hy, input int d);
        if (d == 0) return (hy + 63) % 64;
        if (d == 1) return (hy + 1) % 64;
        return hy;
    endfunction

    task automatic grid_check(input string tag);
        int bad;
        bad = 0;
        for (int i = 0; i < 1200; i++)
            if (mem[i] != ref_grid[i]) bad++;
        chk(tag, bad, 0);
    endtask

    task automatic poke(input int a, input bit v);
        @(negedge clk_25M);
        poke_vld  = 1'b1;
        poke_addr = 11'(a);
        poke_dat  = v;
        @(negedge clk_25M);
        poke_vld  = 1'b0;
        ref_grid[a] = v;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_busy"}, int'(busy), 1);
        chk({tag, "_we"},   int'(ram_we), 0);
        chk({tag, "_addr"}, int'(ram_addr), 0);
        chk({tag, "_din"},  int'(ram_din), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_grow"}, int'(grow), 0);
        chk({tag, "_dead"}, int'(dead), 0);
        chk({tag, "_new"},  int'({new_y, new_x}), 0);
    endtask

    task automatic reset_and_clear();
        int base, fall, bad;
        @(negedge clk_25M);
        rst  = 1'b1;
        tick = 1'b0;
        repeat (3) @(negedge clk_25M);
        check_reset_values("rst");
        base = wr_cnt;
        rst  = 1'b0;
        fall = -1;
        for (int n = 1; n <= 1400; n++) begin
            @(negedge clk_25M);
            if (n == 1) chk("clr_first", int'({ram_we, ram_addr}), 2048);
            if (!busy) begin
                fall = n;
                break;
            end
            tick = ($urandom_range(0, 7) == 0);
        end
        tick = 1'b0;
        chk("clr_busy_fall", fall, 1201);
        chk("clr_writes", wr_cnt - base, 1200);
        bad = 0;
        for (int i = 0; i < 1200; i++) begin
            logic [11:0] e;
            e = wr_log[(base + i) % 16384];
            if (int'(e[10:0]) != i || e[11] != (i >= 607 && i < 610)) bad++;
        end
        chk("clr_sequence", bad, 0);
        for (int i = 0; i < 1200; i++) ref_grid[i] = (i >= 607 && i < 610);
        grid_check("clr_grid");
    endtask

    task automatic step(input int hx, input int hy, input int tx, input int ty,
                        input int ax, input int ay, input int d, output bit died);
        int mx, my, a, ta, nw, exp_done, exp_dead, base;
        int done_cyc, dead_cyc, n_done, got_grow, busy1;
        bit wall, eat, chase, hit;
        int exp_w [2];
        mx    = nxt_x(hx, d);
        my    = nxt_y(hy, d);
        wall  = (mx >= 40) || (my >= 30);
        a     = my * 40 + mx;
        ta    = ty * 40 + tx;
        eat   = (mx == ax) && (my == ay);
        chase = (mx == tx) && (my == ty);
        hit   = wall;
        if (!wall) hit = ref_grid[a] && !(chase && !eat);
        nw       = hit ? 0 : ((eat || chase) ? 1 : 2);
        exp_w[0] = 2048 + a;
        exp_w[1] = ta;
        exp_done = 4 + nw;
        exp_dead = wall ? 3 : 4;

        @(negedge clk_25M);
        head_x = 6'(hx); head_y = 6'(hy);
        tail_x = 6'(tx); tail_y = 6'(ty);
        apple_x = 6'(ax); apple_y = 6'(ay);
        dir  = 2'(d);
        tick = 1'b1;
        base = wr_cnt;
        done_cyc = 0; dead_cyc = 0; n_done = 0; got_grow = 0; busy1 = 0;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk_25M);
            if (c == 1) begin
                tick  = 1'b0;
                busy1 = int'(busy);
            end
            if (done) begin
                n_done++;
                if (done_cyc == 0) begin
                    done_cyc = c;
                    got_grow = int'(grow);
                end
            end
            if (dead && dead_cyc == 0) dead_cyc = c;
        end
        chk("step_busy", busy1, 1);
        chk("step_writes", wr_cnt - base, nw);
        if (hit) begin
            chk("dead_cycle", dead_cyc, exp_dead);
            chk("dead_no_done", n_done, 0);
            base = wr_cnt;
            tick = 1'b1;
            @(negedge clk_25M);
            tick = 1'b0;
            repeat (6) @(negedge clk_25M);
            chk("dead_ignores_tick", (wr_cnt - base) + (busy ? 100 : 0) + (dead ? 0 : 1000), 0);
        end else begin
            chk("done_cycle", done_cyc, exp_done);
            chk("done_once", n_done, 1);
            chk("grow", got_grow, int'(eat));
            chk("new_xy", int'({new_y, new_x}), my * 64 + mx);
            chk("alive", int'(dead), 0);
            for (int k = 0; k < nw; k++)
                chk("write_entry", int'(wr_log[(base + k) % 16384]), exp_w[k]);
            ref_grid[a] = 1'b1;
            if (nw == 2) ref_grid[ta] = 1'b0;
            grid_check("step_grid");
        end
        died = hit;
    endtask

    initial begin
        bit died;
        int hx, hy, d, mx, my, tx, ty, ax, ay;

        reset_and_clear();

        // move right with tail erase, then grow onto the apple, then chase the tail
        step(10, 10, 8, 10, 20, 20, 3, died);
        poke(411, 1'b0);
        step(10, 10, 8, 10, 11, 10, 3, died);
        poke(205, 1'b1);
        step(4, 5, 5, 5, 30, 20, 3, died);

        for (int it = 0; it < 30; it++) begin
            hx = $urandom_range(0, 39);
            hy = $urandom_range(0, 29);
            d  = $urandom_range(0, 3);
            mx = nxt_x(hx, d);
            my = nxt_y(hy, d);
            tx = $urandom_range(0, 39); ty = $urandom_range(0, 29);
            ax = $urandom_range(0, 39); ay = $urandom_range(0, 29);
            if (mx < 40 && my < 30) begin
                if ($urandom_range(0, 9) < 3) begin tx = mx; ty = my; end
                if ($urandom_range(0, 9) < 3) begin ax = mx; ay = my; end
                poke(my * 40 + mx, ($urandom_range(0, 3) == 0));
            end
            step(hx, hy, tx, ty, ax, ay, d, died);
            if (died) reset_and_clear();
        end

        // body hit on a non-tail cell
        poke(205, 1'b1);
        step(4, 5, 0, 0, 30, 20, 3, died);
        reset_and_clear();

        // left off the edge wraps to x=63
        step(0, 5, 3, 5, 20, 20, 2, died);
        reset_and_clear();

        // reset landing in the middle of the head write
        step(10, 10, 8, 10, 20, 20, 3, died);
        @(negedge clk_25M);
        head_x = 6'd11; head_y = 6'd10;
        tail_x = 6'd9;  tail_y = 6'd10;
        dir  = 2'd3;
        tick = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk_25M);
            if (c == 1) tick = 1'b0;
        end
        chk("wrhead_port", int'({ram_we, ram_din, ram_addr}), 4096 + 2048 + 412);
        #5 rst = 1'b1;
        #1 check_reset_values("async_rst");
        reset_and_clear();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
